// File: rtl/pio_uart_tx.sv
// pio_uart_tx: 8N1 UART transmitter (LSB first) fed from a small byte FIFO.
// The bit period is div+1 system clocks. div is latched at each frame start.
module pio_uart_tx #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [7:0]           din,
    input  logic                 push,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 tx
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // FIFO storage and pointers; the extra pointer MSB separates full from empty
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        full_q, empty_q;
    logic        do_push, do_pop;

    // Frame state
    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] timer_q, timer_d;
    logic [DIV_WIDTH-1:0] period_q, period_d;
    logic [8:0]           shreg_q, shreg_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 bit_done;

    // A push into a full FIFO is dropped, even if a pop happens on the same edge
    assign do_push  = push & ~full_q;
    assign bit_done = (timer_q == period_q);

    // Pointer advance for accepted pushes and FSM pops
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // FIFO data write; storage needs no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    // Pointers and flags; flags are registered from the next-state pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                        (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
            empty_q  <= (wr_ptr_d == rd_ptr_d);
        end
    end

    // Next-state logic: bit timing, shifting, frame sequencing and FIFO pops
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        period_d  = period_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        do_pop    = 1'b0;
        tx_d      = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (!empty_q) begin
                    do_pop  = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    timer_d = '0;
                    state_d = StData;
                end else begin
                    timer_d = timer_q + DIV_WIDTH'(1);
                end
            end
            StData: begin
                if (bit_done) begin
                    timer_d   = '0;
                    shreg_d   = {1'b1, shreg_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    timer_d = timer_q + DIV_WIDTH'(1);
                end
            end
            StStop: begin
                if (bit_done) begin
                    timer_d = '0;
                    // Chain straight into the next start bit when more data waits
                    if (!empty_q) begin
                        do_pop  = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q + DIV_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_pop) begin
            shreg_d   = {1'b1, mem[rd_ptr_q[AW-1:0]]};
            period_d  = div;
            timer_d   = '0;
            bit_cnt_d = '0;
        end

        // tx is registered, so it follows the state being entered
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Frame state registers; reset forces the line idle-high immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            period_q  <= '0;
            shreg_q   <= '1;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            period_q  <= period_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign busy  = (state_q != StIdle);
    assign tx    = tx_q;

endmodule

// File: doc/pio_uart_tx.md
# pio_uart_tx

Hardware UART transmitter that drives a serial line (8N1, LSB first) from a small byte FIFO. It is the transmit-side companion to the PIO UART receive program. Its `tx` output connects to a PIO `gpio_in` bit to generate receive stimulus, or to a board pin for host communication. A programmable bit-period divider sets the baud rate in system clock cycles.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `DIV_WIDTH`, 16: width of the `div` port.

Ports:
- `clk`  input  1  system clock; all state is updated on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `div`  input  DIV_WIDTH  bit period minus one; each bit lasts `div`+1 clocks.
- `din`  input  8  byte to enqueue.
- `push`  input  1  enqueue `din` on this clock edge.
- `full`  output  1  FIFO holds `DEPTH` bytes.
- `empty`  output  1  FIFO holds 0 bytes.
- `busy`  output  1  a frame is in progress; high from start bit through stop bit.
- `tx`  output  1  serial line, registered, idle high.

## Operation
- Frame format: start bit (0), then `din[0]` … `din[7]`, then stop bit (1). A frame is 10 bits.
- FIFO
  - Circular buffer with read and write pointers of log2(`DEPTH`)+1 bits; the extra MSB distinguishes full from empty.
  - `push` with `full` low writes `din` and advances the write pointer.
  - `push` with `full` high is ignored. The byte is dropped and no state changes.
  - `full` is evaluated before any same-cycle pop, so a push into a full FIFO is dropped even if a pop happens on the same edge.
- Output FSM states:
  - IDLE: `tx`=1, `busy`=0. If the FIFO is non-empty: pop the head into a 9-bit shift register `{1'b1, byte}`, latch `div` into the period register, drive `tx`=0, clear the bit counter, go to START.
  - START: hold `tx`=0 for `div`+1 clocks, then go to DATA.
  - DATA: emit shift register bit 0 for `div`+1 clocks, then shift right. After 8 bits, go to STOP.
  - STOP: hold `tx`=1 for `div`+1 clocks.
    - On the final cycle, if the FIFO is non-empty, pop and go directly to START with `tx`=0. There is no idle gap.
    - Otherwise go to IDLE.
- Bit timer: counts from 0 up to the latched period, then wraps to 0.
- Arithmetic width rules:
  - The timer and the latched period are DIV_WIDTH bits.
  - The bit counter is 4 bits.
  - `div`=all-ones gives 2^DIV_WIDTH clocks per bit; no overflow is permitted.
- `div` changes mid-frame have no effect until the next frame start.

## Timing
- Reset values: `tx`=1, `busy`=0, `empty`=1, `full`=0. FSM=IDLE, pointers=0, timer=0.
- Reset is asynchronous: asserting `reset` mid-frame forces `tx` high immediately and discards the FIFO contents and the frame in progress.
- `full` and `empty` are registered from the pointers. They reflect a push or pop in the cycle after the edge that performed it.
- Latency: `push` sampled at edge k into an empty FIFO with the FSM idle gives `tx`=0 and `busy`=1 after edge k+1.
- Each bit occupies exactly `div`+1 clocks.
- One frame lasts 10·(`div`+1) clocks.
- After the stop bit of the last queued byte, `busy` falls on the same edge where `tx` stays at 1 and the FSM enters IDLE.
- Back-to-back frames: the stop bit's last cycle is followed immediately by the next start bit.
- Simultaneous push and pop on a non-full FIFO: both take effect and the occupancy is unchanged.

## Test plan
- Reset: assert `reset` for 2 clocks, then release. Required: `tx`=1, `busy`=0, `empty`=1, `full`=0. Assert `reset` again mid-frame: `tx` goes to 1 without waiting for a clock edge.
- Single byte, `div`=0, push 0xA5. Required:
  - `tx` samples 0,1,0,1,0,0,1,0,1,1 on consecutive clocks, starting the cycle after the push.
  - `busy` is high for exactly 10 clocks.
  - `empty` returns to 1.
- Baud timing, `div`=3, push 0x0F. Required: each bit is held 4 clocks, the frame is 40 clocks, and the line reads 0, four 1s, four 0s, then stop 1.
- Back-to-back and overflow with `DEPTH`=4 and `div`=1:
  - Push 0x01..0x05 on 5 consecutive clocks. Required: the first byte starts immediately and 0x02–0x05 are accepted (the FIFO never reaches 4 in time). `full` never drops a byte.
  - With the FSM held busy, push 6 bytes into an empty FIFO. Required: the 5th and 6th pushes are dropped.
  - Every frame is contiguous with no idle cycle between frames.
- Mid-frame divider change: start a frame with `div`=2 and switch `div` to 7 during DATA. Required: the current frame keeps 3-clock bits and the next frame uses 8-clock bits.
- Loopback: drive PIO `gpio_in[0]` from `tx`, running the PIO UART receive program with a matching divider, and send 0x55. Required: PIO `dout` after a pull reads 0x55 in its top byte, and `empty[0]` deasserts.
